// File: rtl/if_stage_controller_pkg.sv
// rtl/if_stage_controller_pkg.sv - shared fetch-stage types and constants
// Contents:
//   ADDR_W_DEF    default fetch address width
//   NOP_INSTR     encoding loaded into IF/ID on a flush
//   fetch_state_e RUN / REQ / FILL controller states
package if_stage_controller_pkg;

  localparam int unsigned ADDR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_stage_controller_sat_counter.sv
// rtl/if_stage_controller_sat_counter.sv - saturating event counter
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset, clears the count
//   inc_i    count one event this cycle
//   count_o  current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/if_stage_controller.sv
// rtl/if_stage_controller.sv - IF/ID sequencing and I-cache refill control
// Ports:
//   clock, reset_n           clock and asynchronous active-low reset
//   pc_in, hit               fetch PC and its I-cache hit flag
//   hazard_stall             ID load-use stall request
//   branch_taken             EX redirect pulse
//   mem_ack, mem_rdata       refill handshake acknowledge and data
//   pc_write, ifid_write     PC / IF/ID load enables (combinational)
//   ifid_flush               IF/ID loads a NOP (combinational)
//   mem_req, mem_addr        refill request and word-aligned address
//   refill_we, refill_data   one-cycle refill write into the I-cache
//   miss_count               saturating miss counter
module if_stage_controller
  import if_stage_controller_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              hit,
  input  logic              hazard_stall,
  input  logic              branch_taken,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              refill_we,
  output logic [31:0]       refill_data,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  fetch_state_e      state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              refill_we_q;
  logic [31:0]       refill_data_q;
  logic              abort_q;
  logic [TIMER_W-1:0] timer_q;

  logic miss_start;
  logic unused_pc_lsbs;

  // Byte offset within the word never reaches memory.
  assign unused_pc_lsbs = ^pc_in[1:0];

  // A miss only opens a transaction when no redirect overrides it.
  assign miss_start = (state_q == ST_RUN) && !branch_taken && !hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      refill_we_q   <= 1'b0;
      refill_data_q <= '0;
      abort_q       <= 1'b0;
      timer_q       <= '0;
    end else begin
      refill_we_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (miss_start) begin
            mem_addr_q <= {pc_in[ADDR_W-1:2], 2'b00};
            mem_req_q  <= 1'b1;
            timer_q    <= '0;
            abort_q    <= 1'b0;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack is only meaningful while the request is actually driven.
          if (mem_req_q && mem_ack) begin
            mem_req_q <= 1'b0;
            timer_q   <= '0;
            if (abort_q || branch_taken) begin
              // Redirected fetch: the word is no longer wanted.
              abort_q <= 1'b0;
              state_q <= ST_RUN;
            end else begin
              refill_data_q <= mem_rdata;
              refill_we_q   <= 1'b1;
              state_q       <= ST_FILL;
            end
          end else begin
            if (branch_taken) begin
              abort_q <= 1'b1;
            end
            if (!mem_req_q) begin
              // End of the one-cycle gap after a timeout: re-issue.
              mem_req_q <= 1'b1;
            end else if (timer_q == TIMER_LAST) begin
              mem_req_q <= 1'b0;
              timer_q   <= '0;
            end else begin
              timer_q <= timer_q + TIMER_W'(1);
            end
          end
        end
        ST_FILL: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    if (state_q == ST_RUN) begin
      if (branch_taken) begin
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
      end else if (!hit) begin
        ifid_flush = !hazard_stall;
      end else if (!hazard_stall) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end else begin
      // Waiting on memory: keep the bubble flowing unless ID holds.
      ifid_flush = !hazard_stall;
      if (branch_taken) begin
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
      end
    end
    // The state register sits in RUN during reset; keep enables quiet.
    if (!reset_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_miss_counter (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .inc_i   (miss_start),
    .count_o (miss_count)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign refill_we   = refill_we_q;
  assign refill_data = refill_data_q;

endmodule

// File: tb/tb_if_stage_controller.sv
// tb/tb_if_stage_controller.sv - scoreboard bench for if_stage_controller
module tb_if_stage_controller;

  typedef struct packed {
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] rd;
    logic [15:0] cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_in = '0;
  logic        hit = 1'b1;
  logic        hazard_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        pc_write, ifid_write, ifid_flush, mem_req, refill_we;
  logic [31:0] mem_addr, refill_data;
  logic [15:0] miss_count;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;

  if_stage_controller #(
    .ADDR_W  (32),
    .TIMEOUT (16),
    .CNT_W   (16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pc_in        (pc_in),
    .hit          (hit),
    .hazard_stall (hazard_stall),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .refill_we    (refill_we),
    .refill_data  (refill_data),
    .miss_count   (miss_count)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic pcw, ifw, fl, req, input logic [31:0] addr,
                              input logic we, input logic [31:0] rd, input logic [15:0] cnt);
    exp_t e;
    e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.req = req;
    e.addr = addr; e.we = we; e.rd = rd; e.cnt = cnt;
    return e;
  endfunction

  // Apply one cycle of inputs just after the edge and queue what must be seen.
  task automatic step(input string name, input logic rst, h, st, br, ack,
                      input logic [31:0] pc, rdata, input exp_t e);
    @(posedge clock);
    #1;
    reset_n      = rst;
    hit          = h;
    hazard_stall = st;
    branch_taken = br;
    mem_ack      = ack;
    pc_in        = pc;
    mem_rdata    = rdata;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: every cycle presents outputs; compare against the oldest entry.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {pc_write, ifid_write, ifid_flush, mem_req, mem_addr, refill_we, refill_data, miss_count};
        n_vec++;
        if (a !== e || (ifid_write && ifid_flush)) begin
          n_bad++;
          $display("FAIL %s (cyc %0d): got pcw=%b ifw=%b fl=%b req=%b addr=%h we=%b rd=%h cnt=%0d, want pcw=%b ifw=%b fl=%b req=%b addr=%h we=%b rd=%h cnt=%0d",
                   nm, cyc, a.pcw, a.ifw, a.fl, a.req, a.addr, a.we, a.rd, a.cnt,
                   e.pcw, e.ifw, e.fl, e.req, e.addr, e.we, e.rd, e.cnt);
        end
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step("reset", 0, 1, 0, 0, 0, 32'h0, 32'h0, mk(0,0,0,0, 32'h0, 0, 32'h0, 0));
    step("reset", 0, 1, 0, 0, 0, 32'h0, 32'h0, mk(0,0,0,0, 32'h0, 0, 32'h0, 0));

    // Hits every cycle
    for (int i = 0; i < 4; i++)
      step("hit_run", 1, 1, 0, 0, 0, 32'h100 + 4*i, 32'h0, mk(1,1,0,0, 32'h0, 0, 32'h0, 0));

    // Miss at 0x1006, ack on third REQ cycle
    step("miss_b c0", 1, 0, 0, 0, 0, 32'h1006, 32'h0, mk(0,0,1,0, 32'h0, 0, 32'h0, 0));
    step("miss_b c1", 1, 0, 0, 0, 0, 32'h1006, 32'h0, mk(0,0,1,1, 32'h1004, 0, 32'h0, 1));
    step("miss_b c2", 1, 0, 0, 0, 0, 32'h1006, 32'h0, mk(0,0,1,1, 32'h1004, 0, 32'h0, 1));
    step("miss_b ack", 1, 0, 0, 0, 1, 32'h1006, 32'h2008_0005, mk(0,0,1,1, 32'h1004, 0, 32'h0, 1));
    step("miss_b fill", 1, 0, 0, 0, 0, 32'h1006, 32'h0, mk(0,0,1,0, 32'h1004, 1, 32'h2008_0005, 1));
    step("miss_b refetch", 1, 1, 0, 0, 0, 32'h1006, 32'h0, mk(1,1,0,0, 32'h1004, 0, 32'h2008_0005, 1));

    // Timeout: 16 cycles of request, one-cycle gap, re-issue, ack
    step("tmo miss", 1, 0, 0, 0, 0, 32'h2000, 32'h0, mk(0,0,1,0, 32'h1004, 0, 32'h2008_0005, 1));
    for (int i = 0; i < 16; i++)
      step("tmo req", 1, 0, 0, 0, 0, 32'h2000, 32'h0, mk(0,0,1,1, 32'h2000, 0, 32'h2008_0005, 2));
    step("tmo gap", 1, 0, 0, 0, 0, 32'h2000, 32'h0, mk(0,0,1,0, 32'h2000, 0, 32'h2008_0005, 2));
    step("tmo reissue ack", 1, 0, 0, 0, 1, 32'h2000, 32'hCAFE_0001, mk(0,0,1,1, 32'h2000, 0, 32'h2008_0005, 2));
    step("tmo fill", 1, 0, 0, 0, 0, 32'h2000, 32'h0, mk(0,0,1,0, 32'h2000, 1, 32'hCAFE_0001, 2));
    step("tmo refetch", 1, 1, 0, 0, 0, 32'h2000, 32'h0, mk(1,1,0,0, 32'h2000, 0, 32'hCAFE_0001, 2));

    // Branch during REQ, later ack -> abort, no refill
    step("abort miss", 1, 0, 0, 0, 0, 32'h3008, 32'h0, mk(0,0,1,0, 32'h2000, 0, 32'hCAFE_0001, 2));
    step("abort branch", 1, 0, 0, 1, 0, 32'h3008, 32'h0, mk(1,0,1,1, 32'h3008, 0, 32'hCAFE_0001, 3));
    step("abort ack", 1, 0, 0, 0, 1, 32'h3008, 32'hDEAD_BEEF, mk(0,0,1,1, 32'h3008, 0, 32'hCAFE_0001, 3));
    step("abort run", 1, 1, 0, 0, 0, 32'h3100, 32'h0, mk(1,1,0,0, 32'h3008, 0, 32'hCAFE_0001, 3));

    // Branch and ack in the same cycle -> abort
    step("brack miss", 1, 0, 0, 0, 0, 32'h4000, 32'h0, mk(0,0,1,0, 32'h3008, 0, 32'hCAFE_0001, 3));
    step("brack both", 1, 0, 0, 1, 1, 32'h4000, 32'h5555_AAAA, mk(1,0,1,1, 32'h4000, 0, 32'hCAFE_0001, 4));
    step("brack run", 1, 1, 0, 0, 0, 32'h4100, 32'h0, mk(1,1,0,0, 32'h4000, 0, 32'hCAFE_0001, 4));

    // Branch in FILL still writes; branch with miss in RUN opens no request
    step("fillbr miss", 1, 0, 0, 0, 0, 32'h5004, 32'h0, mk(0,0,1,0, 32'h4000, 0, 32'hCAFE_0001, 4));
    step("fillbr ack", 1, 0, 0, 0, 1, 32'h5004, 32'h1111_2222, mk(0,0,1,1, 32'h5004, 0, 32'hCAFE_0001, 5));
    step("fillbr fill", 1, 0, 0, 1, 0, 32'h5004, 32'h0, mk(1,0,1,0, 32'h5004, 1, 32'h1111_2222, 5));
    step("fillbr run", 1, 1, 0, 0, 0, 32'h5200, 32'h0, mk(1,1,0,0, 32'h5004, 0, 32'h1111_2222, 5));
    step("run br+miss", 1, 0, 0, 1, 0, 32'h6000, 32'h0, mk(1,0,1,0, 32'h5004, 0, 32'h1111_2222, 5));
    step("run after br", 1, 1, 0, 0, 0, 32'h6000, 32'h0, mk(1,1,0,0, 32'h5004, 0, 32'h1111_2222, 5));

    // Hazard stall with hit, then with miss through REQ/FILL
    step("stall hit", 1, 1, 1, 0, 0, 32'h6004, 32'h0, mk(0,0,0,0, 32'h5004, 0, 32'h1111_2222, 5));
    step("stall miss", 1, 0, 1, 0, 0, 32'h7000, 32'h0, mk(0,0,0,0, 32'h5004, 0, 32'h1111_2222, 5));
    step("stall req", 1, 0, 1, 0, 0, 32'h7000, 32'h0, mk(0,0,0,1, 32'h7000, 0, 32'h1111_2222, 6));
    step("stall ack", 1, 0, 1, 0, 1, 32'h7000, 32'h3333_4444, mk(0,0,0,1, 32'h7000, 0, 32'h1111_2222, 6));
    step("stall fill", 1, 0, 1, 0, 0, 32'h7000, 32'h0, mk(0,0,0,0, 32'h7000, 1, 32'h3333_4444, 6));
    step("stall release", 1, 1, 0, 0, 0, 32'h7000, 32'h0, mk(1,1,0,0, 32'h7000, 0, 32'h3333_4444, 6));

    // Asynchronous reset mid-REQ
    step("rst miss", 1, 0, 0, 0, 0, 32'h8000, 32'h0, mk(0,0,1,0, 32'h7000, 0, 32'h3333_4444, 6));
    step("rst req", 1, 0, 0, 0, 0, 32'h8000, 32'h0, mk(0,0,1,1, 32'h8000, 0, 32'h3333_4444, 7));
    step("rst assert", 0, 0, 0, 0, 0, 32'h8000, 32'h0, mk(0,0,0,0, 32'h0, 0, 32'h0, 0));
    step("rst release", 1, 1, 0, 0, 0, 32'h8000, 32'h0, mk(1,1,0,0, 32'h0, 0, 32'h0, 0));
    step("rst run", 1, 1, 0, 0, 0, 32'h8004, 32'h0, mk(1,1,0,0, 32'h0, 0, 32'h0, 0));

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
